// File: rtl/global_buffer_param.sv
// Global buffer constants shared by the bank-side blocks.
package global_buffer_param;
    localparam int BANK_DATA_WIDTH = 64;
    localparam int GLB_RD_LATENCY  = 3;
    localparam int GLB_TAG_WIDTH   = 8;
endpackage

// File: rtl/global_buffer_pkg.sv
// Global buffer types: a bank read response is a data word plus its request tag.
package global_buffer_pkg;
    import global_buffer_param::*;

    typedef struct packed {
        logic [BANK_DATA_WIDTH-1:0] data;
        logic [GLB_TAG_WIDTH-1:0]   tag;
    } rd_rsp_t;

    localparam int RD_RSP_WIDTH = $bits(rd_rsp_t);
endpackage

// File: rtl/glb_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is read combinationally.
module glb_sync_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & (count_r != CW'(DEPTH));
    assign pop_ok_s  = pop & (count_r != {CW{1'b0}});
    assign head_data = mem_r[rd_ptr_r];
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/glb_bank_rd_rsp_buffer.sv
// Bank read issue/response buffer: issues reads under a credit check, tracks the
// fixed bank latency and queues tagged responses for the consumer.
module glb_bank_rd_rsp_buffer
    import global_buffer_param::*;
    import global_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = BANK_DATA_WIDTH,
    parameter int TAG_WIDTH  = GLB_TAG_WIDTH,
    parameter int RD_LATENCY = GLB_RD_LATENCY,
    parameter int FIFO_DEPTH = 8,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [TAG_WIDTH-1:0]  rd_req_tag,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [CW-1:0]         inflight_cnt,
    output logic [CW-1:0]         fifo_cnt
);
    // Equals RD_RSP_WIDTH for the default bank configuration.
    localparam int RSP_W = DATA_WIDTH + TAG_WIDTH;

    logic                  init_r;
    logic [RD_LATENCY-1:0] vld_pipe_r;
    logic [TAG_WIDTH-1:0]  tag_pipe_r [RD_LATENCY];
    logic [CW-1:0]         inflight_r;
    logic [CW:0]           credit_sum_s;
    logic                  accept_s;
    logic                  capture_s;
    logic                  pop_s;
    logic                  fifo_empty_s;
    logic [CW-1:0]         fifo_cnt_s;
    logic [RSP_W-1:0]      head_s;

    // Credit uses registered counts only, so rsp_ready never reaches rd_req_ready.
    assign credit_sum_s = {1'b0, inflight_r} + {1'b0, fifo_cnt_s};
    assign rd_req_ready = init_r & (credit_sum_s < (CW + 1)'(FIFO_DEPTH));
    assign accept_s     = rd_req_valid & rd_req_ready;
    assign mem_ren      = accept_s;
    assign capture_s    = vld_pipe_r[RD_LATENCY-1];
    assign pop_s        = rsp_valid & rsp_ready;

    assign rsp_valid    = ~fifo_empty_s;
    assign rsp_data     = head_s[RSP_W-1:TAG_WIDTH];
    assign rsp_tag      = head_s[TAG_WIDTH-1:0];
    assign inflight_cnt = inflight_r;
    assign fifo_cnt     = fifo_cnt_s;

    // Init flop holds off requests until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_r <= 1'b0;
        end else begin
            init_r <= 1'b1;
        end
    end

    // Latency tracking pipeline: shifts every cycle, never stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_r <= {RD_LATENCY{1'b0}};
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_pipe_r[i] <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            vld_pipe_r[0] <= accept_s;
            tag_pipe_r[0] <= rd_req_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                tag_pipe_r[i] <= tag_pipe_r[i-1];
            end
        end
    end

    // Reads issued to the bank but not yet captured into the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_r <= {CW{1'b0}};
        end else begin
            case ({accept_s, capture_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    glb_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture_s),
        .push_data ({mem_data_out, tag_pipe_r[RD_LATENCY-1]}),
        .pop       (pop_s),
        .head_data (head_s),
        .empty     (fifo_empty_s),
        .count     (fifo_cnt_s)
    );
endmodule

// File: tb/tb_glb_bank_rd_rsp_buffer.sv
// Directed and randomized bench for glb_bank_rd_rsp_buffer against an in-order response model.
module tb_glb_bank_rd_rsp_buffer;
    localparam int L     = 3;
    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [7:0]  rd_req_tag;
    logic        mem_ren;
    logic [63:0] mem_data_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic [3:0]  inflight_cnt;
    logic [3:0]  fifo_cnt;

    glb_bank_rd_rsp_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_tag   (rd_req_tag),
        .mem_ren      (mem_ren),
        .mem_data_out (mem_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .inflight_cnt (inflight_cnt),
        .fifo_cnt     (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: the word presented with mem_ren comes back L cycles later; garbage otherwise.
    logic [63:0] bank_word;
    logic [63:0] bank_pipe [L];
    always @(posedge clk) begin
        bank_pipe[0] <= mem_ren ? bank_word : {$urandom, $urandom};
        for (int i = 1; i < L; i++) bank_pipe[i] <= bank_pipe[i-1];
    end
    assign mem_data_out = bank_pipe[L-1];

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   rel_edges = 0;
    bit   in_rst  = 1'b1;
    int   obs_acc = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    endtask

    // One clock cycle: drive inputs, check all outputs at the falling edge, update the model.
    task automatic step(input logic rst_v, input logic v, input logic [7:0] t, input logic r);
        int  nf, ni;
        bit  exp_rdy, exp_vld, acc, pop;
        reset = rst_v; rd_req_valid = v; rd_req_tag = t; rsp_ready = r;
        if (!rst_v) begin
            in_rst = 1'b1;
            rel_edges = 0;
            q.delete();
        end else begin
            in_rst = 1'b0;
        end
        @(negedge clk);
        nf = 0;
        foreach (q[i]) if (q[i].acc + L < cyc) nf++;
        ni = q.size() - nf;
        exp_rdy = !in_rst && (rel_edges >= 1) && (q.size() < DEPTH);
        exp_vld = (nf > 0);
        acc = v && exp_rdy;
        pop = r && exp_vld;
        check("rd_req_ready", 64'(rd_req_ready), 64'(exp_rdy));
        check("mem_ren", 64'(mem_ren), 64'(acc));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
        check("inflight_cnt", 64'(inflight_cnt), 64'(ni));
        check("fifo_cnt", 64'(fifo_cnt), 64'(nf));
        if (exp_vld) begin
            check("rsp_data", rsp_data, q[0].data);
            check("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
        end else if (in_rst) begin
            check("rst_rsp_data", rsp_data, 64'h0);
            check("rst_rsp_tag", 64'(rsp_tag), 64'h0);
        end
        if (mem_ren === 1'b1) obs_acc++;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{data: bank_word, tag: t, acc: cyc});
        @(posedge clk);
        #1;
        cyc++;
        if (!in_rst) rel_edges++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        reset = 1'b0; rd_req_valid = 1'b0; rd_req_tag = 8'h00; rsp_ready = 1'b0;
        bank_word = 64'h0;

        // Reset and init: request held valid through reset and release.
        bank_word = 64'hA5A5;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h11, 1'b1);
        obs_acc = 0;
        step(1'b1, 1'b1, 8'h11, 1'b0);
        check("no_accept_on_release", 64'(obs_acc), 64'd0);
        step(1'b1, 1'b1, 8'h11, 1'b0);
        check("first_accept", 64'(obs_acc), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        check("init_rsp_valid", 64'(rsp_valid), 64'd1);
        check("init_rsp_data", rsp_data, 64'hA5A5);
        check("init_rsp_tag", 64'(rsp_tag), 64'h11);
        drain(12);

        // Streaming: 16 back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            bank_word = 64'(i) * 64'h0101;
            step(1'b1, 1'b1, 8'(i), 1'b1);
        end
        drain(8);

        // Backpressure until the credit runs out.
        obs_acc = 0;
        for (int i = 0; i < 20; i++) begin
            bank_word = {$urandom, $urandom};
            step(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0);
        end
        check("bp_accepts", 64'(obs_acc), 64'd8);
        check("bp_fifo_full", 64'(fifo_cnt), 64'd8);
        check("bp_inflight_zero", 64'(inflight_cnt), 64'd0);
        check("bp_ready_low", 64'(rd_req_ready), 64'd0);
        check("bp_head_tag", 64'(rsp_tag), 64'h40);
        step(1'b1, 1'b1, 8'h60, 1'b1);
        obs_acc = 0;
        step(1'b1, 1'b1, 8'h61, 1'b0);
        step(1'b1, 1'b1, 8'h62, 1'b0);
        check("bp_one_reaccept", 64'(obs_acc), 64'd1);
        drain(16);

        // Capture and pop together on a one-entry FIFO.
        bank_word = 64'h1111_2222_3333_4444;
        step(1'b1, 1'b1, 8'hA1, 1'b0);
        bank_word = 64'h5555_6666_7777_8888;
        step(1'b1, 1'b1, 8'hB2, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("simul_fifo_cnt", 64'(fifo_cnt), 64'd1);
        check("simul_rsp_valid", 64'(rsp_valid), 64'd1);
        check("simul_head_tag", 64'(rsp_tag), 64'hB2);
        drain(6);

        // Reset with three reads in flight and two responses queued.
        for (int i = 0; i < 5; i++) begin
            bank_word = {$urandom, $urandom};
            step(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0);
        end
        check("mid_fifo_cnt", 64'(fifo_cnt), 64'd2);
        check("mid_inflight", 64'(inflight_cnt), 64'd3);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        drain(12);

        // Random soak.
        for (int i = 0; i < 10000; i++) begin
            bank_word = {$urandom, $urandom};
            step(1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) != 0));
            check("credit_bound", 64'((32'(inflight_cnt) + 32'(fifo_cnt)) <= DEPTH), 64'd1);
        end
        drain(16);
        check("soak_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
